pio_in_debounced: RTL and testbench
===================================

Name: pio_in_debounced

Overview:
- Parametrised successor to the Avalon-MM input PIO used for the DE2-115 keys and switches.
- Per-bit input flow: 2-flop synchroniser, then debouncer, then edge detector, then edge-capture register, then maskable interrupt to the Nios II.
- Avalon-MM slave, registered readdata with read latency 1.
- Intended to replace the plain key/switch PIOs in the SOPC so that the software no longer needs to debounce the inputs.

Parameters:
WIDTH, 4, number of input bits (1..32)
DEBOUNCE_CYCLES, 16, number of consecutive stable cycles required to accept a new level; 0 bypasses the debouncer
EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 any
IRQ_TYPE, 0, 0 edge (irq from edgecapture), 1 level (irq from debounced data)
RESET_MASK, 0, reset value of irqmask (WIDTH bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt request to the CPU

Behaviour:
- Reset: synchronous to clk, active-high. While reset=1 at a clk edge:
  - sync flops, stable, debounce counters and edgecapture clear to 0.
  - irqmask is set to RESET_MASK.
  - readdata and irq are 0.
  - Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per bit. sync2 = in_port delayed by 2 edges.
- Debounce (per bit, counter width $clog2(DEBOUNCE_CYCLES+1)):
  - If sync2 != stable: the counter increments. When it reaches DEBOUNCE_CYCLES-1 with a mismatch still present, stable <= sync2 and the counter returns to 0.
  - If sync2 == stable: the counter is cleared. Any bounce therefore restarts the count.
  - DEBOUNCE_CYCLES=0: stable <= sync2 every cycle.
  - Latency from in_port change to stable change: 2+DEBOUNCE_CYCLES edges, with the bypass giving 3 edges. readdata follows 1 edge later.
- Edge detect: compare stable against stable_d (stable delayed by 1). Rise = stable & ~stable_d; fall is the inverse; any = XOR. EDGE_TYPE selects which one is used.
- edgecapture[i] is sticky:
  - Set on the selected edge.
  - Cleared by a write to offset 3 with writedata[i]=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Register map (word offsets). Write = chipselect & ~write_n:
  - 0 data: read stable, zero-extended. Writes ignored.
  - 1: reads 0. Writes ignored.
  - 2 irqmask: R/W over WIDTH bits. Upper writedata bits ignored, upper read bits 0.
  - 3 edgecapture: read the capture register. Write 1 to clear; write 0 has no effect.
- readdata:
  - Registered and updated every clk from the current address, regardless of chipselect, as the existing PIOs do.
  - Bits [31:WIDTH] are always 0.
  - A read of offset 3 in the same cycle as a clearing write returns the pre-clear value.
- irq:
  - Registered.
  - IRQ_TYPE 0: irq = |(edgecapture & irqmask).
  - IRQ_TYPE 1: irq = |(stable & irqmask).
  - irq stays asserted until the source bit or the mask bit is cleared; it deasserts 1 edge later.
- WIDTH=32: no zero-extension is needed. WIDTH<32: unused bits are tied to 0.

Decomposition:
- Package pio_in_pkg:
  - Register offset constants: REG_DATA=0, REG_DIR=1, REG_IRQMASK=2, REG_EDGECAP=3.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
  - IRQ_EDGE/IRQ_LEVEL encodings.
- Sub-module pio_debounce_bit: one channel of synchroniser plus debouncer, instantiated WIDTH times via generate. The top level holds edge detect, the registers, the read mux and irq.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, IRQ_TYPE=0 unless stated):
1. Hold reset=1 for 2 edges, then read offsets 0, 2 and 3 -> readdata=0x0 for all three; irq=0.
2. Drive in_port=0x1 and hold -> stable bit0 rises exactly 6 edges after the change. Reading offset 0 returns 0x00000001. edgecapture=0x1.
3. Toggle in_port bit1 every 3 cycles (bounce shorter than 4) for 30 cycles, then return to 0 -> data bit1 never changes; edgecapture bit1 stays 0.
4. Write irqmask=0x1 with edgecapture=0x1 -> irq=1 one edge later. Write 0x1 to offset 3 -> edgecapture=0, and irq=0 one edge later.
5. Make an edge on bit2 coincide with a write of 0x4 to offset 3 -> edgecapture bit2 remains 1 (set wins).
6. Configure EDGE_TYPE=2, IRQ_TYPE=1, DEBOUNCE_CYCLES=0, irqmask=0x8, then set in_port=0x8 -> stable changes 3 edges after the change and irq=1 on the next edge. Clearing in_port deasserts irq, and every edge sets edgecapture bit3.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced input PIO: Avalon register offsets and
// the encodings of the edge-select and interrupt-mode parameters.
package pio_in_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_DIR     = 2'd1;
    localparam logic [1:0] REG_IRQMASK = 2'd2;
    localparam logic [1:0] REG_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned IRQ_EDGE  = 0;
    localparam int unsigned IRQ_LEVEL = 1;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: two-flop synchroniser followed by a stable-count debouncer.
// DEBOUNCE_CYCLES=0 reduces the debouncer to a single retiming flop.
module pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic stable_o
);

    logic sync1_q;
    logic sync2_q;
    logic stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= 1'b0;
            end else begin
                stable_q <= sync2_q;
            end
        end
    end else begin : g_filter
        localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          stable_d;

        // Any cycle where the input agrees with the accepted level restarts the count.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/pio_in_debounced.sv
// Avalon-MM input PIO with per-bit debouncing, sticky edge capture and a
// maskable interrupt; drop-in successor to the plain key/switch PIO.
module pio_in_debounced
    import pio_in_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter int unsigned      IRQ_TYPE        = 0,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .din_i   (in_port[i]),
            .stable_o(stable[i])
        );
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_hit = ~stable & stable_dly_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = stable ^ stable_dly_q;
        end else begin
            edge_hit = stable & ~stable_dly_q;
        end
    end

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && (address == REG_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == REG_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // A new edge overrides a simultaneous write-1-to-clear.
        edgecap_d = edgecap_d | edge_hit;

        // Read mux uses pre-write register values, so a clearing write reads old data.
        readdata_d = '0;
        case (address)
            REG_DATA:    readdata_d[WIDTH-1:0] = stable;
            REG_DIR:     readdata_d = '0;
            REG_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            REG_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:     readdata_d = '0;
        endcase

        if (IRQ_TYPE == IRQ_LEVEL) begin
            irq_d = |(stable & irqmask_q);
        end else begin
            irq_d = |(edgecap_q & irqmask_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_dly_q <= '0;
            irqmask_q    <= RESET_MASK;
            edgecap_q    <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            stable_dly_q <= stable;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_debounced.sv
// Directed bench for pio_in_debounced: one instance with the default test
// configuration and one with any-edge capture, level irq and no debouncing.
module tb_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    logic [1:0]  address2;
    logic        chipselect2;
    logic        write_n2;
    logic [31:0] writedata2;
    logic [31:0] readdata2;
    logic [3:0]  in_port2;
    logic        irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_debounced #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (0),
        .IRQ_TYPE       (0),
        .RESET_MASK     (4'h0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    pio_in_debounced #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(0),
        .EDGE_TYPE      (2),
        .IRQ_TYPE       (1),
        .RESET_MASK     (4'h0)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .address   (address2),
        .chipselect(chipselect2),
        .write_n   (write_n2),
        .writedata (writedata2),
        .readdata  (readdata2),
        .in_port   (in_port2),
        .irq       (irq2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] a, input logic [31:0] d);
        address2    = a;
        writedata2  = d;
        chipselect2 = 1'b1;
        write_n2    = 1'b0;
        @(negedge clk);
        chipselect2 = 1'b0;
        write_n2    = 1'b1;
    endtask

    task automatic rd2(input logic [1:0] a, output logic [31:0] d);
        address2    = a;
        chipselect2 = 1'b1;
        write_n2    = 1'b1;
        @(negedge clk);
        d           = readdata2;
        chipselect2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          first;
        int          first_irq;
        logic        seen;

        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        in_port     = '0;
        address2    = 2'd0;
        chipselect2 = 1'b0;
        write_n2    = 1'b1;
        writedata2  = '0;
        in_port2    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_irq2", {31'b0, irq2}, 32'h0);
        reset = 1'b0;
        rd(2'd0, d); check("rst_rd_data", d, 32'h0);
        rd(2'd2, d); check("rst_rd_mask", d, 32'h0);
        rd(2'd3, d); check("rst_rd_ecap", d, 32'h0);
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        // Debounce latency: stable at edge 6, visible on readdata at edge 7
        address = 2'd0;
        in_port = 4'h1;
        first   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (first == 0 && readdata[0]) first = k;
        end
        check("lat_data", first, 32'd7);
        rd(2'd0, d); check("rd_data_b0", d, 32'h1);
        rd(2'd3, d); check("rd_ecap_b0", d, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);

        // Bounce shorter than the debounce window must be rejected
        address = 2'd0;
        seen    = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) in_port[1] = ~in_port[1];
            @(negedge clk);
            seen = seen | readdata[1];
        end
        in_port[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen = seen | readdata[1];
        end
        check("bounce_data", {31'b0, seen}, 32'h0);
        rd(2'd3, d); check("bounce_ecap", d, 32'h1);

        // Mask, irq assertion and clear; upper writedata bits ignored
        wr(2'd2, 32'hFFFF_FFF1);
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'h1);
        rd(2'd2, d); check("rd_mask", d, 32'h1);
        wr(2'd1, 32'hF);
        rd(2'd1, d); check("rd_dir", d, 32'h0);
        wr(2'd3, 32'h1);
        check("rd_preclear", readdata, 32'h1);
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_clear", {31'b0, irq}, 32'h0);
        rd(2'd3, d); check("ecap_cleared", d, 32'h0);

        // Edge on bit2 coincides with a clearing write: capture must survive
        in_port[2] = 1'b1;
        repeat (6) @(negedge clk);
        wr(2'd3, 32'h4);
        check("set_wins_pre", readdata, 32'h0);
        @(negedge clk);
        check("set_wins", readdata, 32'h4);
        wr(2'd3, 32'h0);
        rd(2'd3, d); check("wr0_no_effect", d, 32'h4);
        check("irq_bit2_masked", {31'b0, irq}, 32'h0);

        // Second instance: bypassed debounce, any-edge capture, level irq
        wr2(2'd2, 32'h8);
        address2  = 2'd0;
        in_port2  = 4'h8;
        first     = 0;
        first_irq = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (first == 0 && readdata2[3]) first = k;
            if (first_irq == 0 && irq2) first_irq = k;
        end
        check("byp_lat_data", first, 32'd4);
        check("byp_lat_irq", first_irq, 32'd4);
        rd2(2'd3, d); check("byp_ecap_rise", d, 32'h8);
        wr2(2'd3, 32'h8);
        rd2(2'd3, d); check("byp_ecap_clr", d, 32'h0);
        address2  = 2'd0;
        in_port2  = 4'h0;
        first_irq = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (first_irq == 0 && !irq2) first_irq = k;
        end
        check("byp_irq_fall", first_irq, 32'd4);
        rd2(2'd3, d); check("byp_ecap_fall", d, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
